// File: rtl/debug_pkg.sv
// Shared types and defaults for the debug UART TX arbiter: FSM encoding,
// heartbeat frame bytes and watchdog reload values.
package debug_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        ETH      = 2'd1,
        HB_START = 2'd2,
        HB_CODE  = 2'd3
    } state_t;

    localparam int          FIFO_DEPTH_DEFAULT = 16;
    localparam logic [7:0]  START_BYTE_DEFAULT = 8'h68;
    localparam logic [7:0]  WDOG_CODE_DEFAULT  = 8'h65;
    // 30 s at 50 MHz for silicon; a short period keeps simulation fast.
    localparam logic [31:0] WDOG_TICKS_SYNTH   = 32'h5968_2EFF;
    localparam logic [31:0] WDOG_TICKS_SIM     = 32'd16;

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

endpackage

// File: rtl/debug_tx_arbiter_if.sv
// Byte-level signals between the Ethernet receive tap, the arbiter and the UART TX.
// Handshake: a byte moves on every cycle with o_wvalid && i_wready; while o_wvalid=1 and i_wready=0, o_wdata holds.
interface debug_tx_arbiter_if;
    logic [7:0] i_eth_rdata;
    logic       i_eth_rready;
    logic       i_wready;
    logic [7:0] o_wdata;
    logic       o_wvalid;

    modport master (
        input  i_eth_rdata,
        input  i_eth_rready,
        input  i_wready,
        output o_wdata,
        output o_wvalid
    );

    modport slave (
        output i_eth_rdata,
        output i_eth_rready,
        output i_wready,
        input  o_wdata,
        input  o_wvalid
    );
endinterface

// File: rtl/debug_byte_fifo.sv
// Synchronous 8-bit FIFO with registered occupancy; the head byte is visible
// on rdata without a read latency so the arbiter can load it on the pop edge.
module debug_byte_fifo #(
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic [7:0]               wdata,
    output logic [7:0]               rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);
    localparam int          AW       = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] wr_ptr;
    logic [AW:0]   count;
    logic          do_push;
    logic          do_pop;

    assign full    = (count == FULL_CNT);
    assign empty   = (count == '0);
    assign do_pop  = pop && !empty;
    // A full FIFO still takes a byte when the head leaves on the same edge.
    assign do_push = push && (!full || do_pop);
    assign rdata   = mem[rd_ptr];
    assign level   = count;

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= wdata;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end
endmodule

// File: rtl/debug_tx_arbiter.sv
// Shares the debug UART TX byte channel between buffered Ethernet bytes and
// an idle-watchdog heartbeat frame (START_BYTE, WDOG_CODE) that is never split.
module debug_tx_arbiter
    import debug_pkg::*;
#(
    parameter int          FIFO_DEPTH = FIFO_DEPTH_DEFAULT,
    parameter logic [31:0] WDOG_TICKS = WDOG_TICKS_SYNTH,
    parameter logic [7:0]  START_BYTE = START_BYTE_DEFAULT,
    parameter logic [7:0]  WDOG_CODE  = WDOG_CODE_DEFAULT
) (
    input  logic                          i_clk,
    input  logic                          i_rst,
    debug_tx_arbiter_if.master            bus,
    output logic                          o_busy,
    output logic [$clog2(FIFO_DEPTH):0]   o_fifo_level,
    output logic [7:0]                    o_drop_cnt,
    output state_t                        o_state
);
    state_t      state_q;
    state_t      state_d;
    logic [7:0]  wdata_q;
    logic [7:0]  wdata_d;
    logic        wvalid_q;
    logic        wvalid_d;
    logic        busy_q;
    logic        fifo_pop;
    logic        fifo_full;
    logic        fifo_empty;
    logic [7:0]  fifo_rdata;
    logic [31:0] wdog_q;
    logic        hb_pend_q;
    logic [7:0]  drop_q;
    logic        handoff;
    logic        code_done;
    logic        drop;

    assign handoff   = wvalid_q && bus.i_wready;
    assign code_done = handoff && (state_q == HB_CODE);
    assign drop      = bus.i_eth_rready && fifo_full && !fifo_pop;

    debug_byte_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (i_clk),
        .rst   (i_rst),
        .push  (bus.i_eth_rready),
        .pop   (fifo_pop),
        .wdata (bus.i_eth_rdata),
        .rdata (fifo_rdata),
        .full  (fifo_full),
        .empty (fifo_empty),
        .level (o_fifo_level)
    );

    // Heartbeat wins in IDLE; once HB_START is entered the frame runs to completion.
    always_comb begin
        state_d  = state_q;
        wdata_d  = wdata_q;
        wvalid_d = wvalid_q;
        fifo_pop = 1'b0;
        case (state_q)
            IDLE: begin
                wvalid_d = 1'b0;
                if (hb_pend_q) begin
                    state_d  = HB_START;
                    wdata_d  = START_BYTE;
                    wvalid_d = 1'b1;
                end else if (!fifo_empty) begin
                    fifo_pop = 1'b1;
                    state_d  = ETH;
                    wdata_d  = fifo_rdata;
                    wvalid_d = 1'b1;
                end
            end
            ETH: begin
                if (handoff) begin
                    state_d  = IDLE;
                    wvalid_d = 1'b0;
                end
            end
            HB_START: begin
                if (handoff) begin
                    state_d  = HB_CODE;
                    wdata_d  = WDOG_CODE;
                    wvalid_d = 1'b1;
                end
            end
            HB_CODE: begin
                if (handoff) begin
                    state_d  = IDLE;
                    wvalid_d = 1'b0;
                end
            end
            default: begin
                state_d  = IDLE;
                wvalid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q  <= IDLE;
            wdata_q  <= 8'h00;
            wvalid_q <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            wdata_q  <= wdata_d;
            wvalid_q <= wvalid_d;
            busy_q   <= (state_d != IDLE);
        end
    end

    // Any Ethernet strobe restarts the idle period, but never cancels a pending frame.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            wdog_q    <= WDOG_TICKS;
            hb_pend_q <= 1'b0;
            drop_q    <= 8'h00;
        end else begin
            if (bus.i_eth_rready || code_done) begin
                wdog_q <= WDOG_TICKS;
            end else if (wdog_q != 32'd0) begin
                wdog_q <= wdog_q - 32'd1;
            end
            if (code_done) begin
                hb_pend_q <= 1'b0;
            end else if (wdog_q == 32'd0) begin
                hb_pend_q <= 1'b1;
            end
            if (drop) begin
                drop_q <= sat_inc8(drop_q);
            end
        end
    end

    assign bus.o_wdata  = wdata_q;
    assign bus.o_wvalid = wvalid_q;
    assign o_busy       = busy_q;
    assign o_drop_cnt   = drop_q;
    assign o_state      = state_q;
endmodule

// File: tb/tb_debug_tx_arbiter.sv
// Bench for debug_tx_arbiter with a 4-deep FIFO and a 16-cycle watchdog:
// hand-derived vector table, directed multi-cycle sequences, then random traffic against a reference model.
module tb_debug_tx_arbiter;
    import debug_pkg::*;

    localparam int DEPTH = 4;
    localparam int W     = 16;
    localparam int LW    = $clog2(DEPTH) + 1;
    localparam int NROWS = 28;

    logic          i_clk = 1'b0;
    logic          i_rst;
    logic          o_busy;
    logic [LW-1:0] o_fifo_level;
    logic [7:0]    o_drop_cnt;
    state_t        o_state;

    debug_tx_arbiter_if bus();

    debug_tx_arbiter #(
        .FIFO_DEPTH (DEPTH),
        .WDOG_TICKS (32'd16),
        .START_BYTE (8'h68),
        .WDOG_CODE  (8'h65)
    ) dut (
        .i_clk        (i_clk),
        .i_rst        (i_rst),
        .bus          (bus),
        .o_busy       (o_busy),
        .o_fifo_level (o_fifo_level),
        .o_drop_cnt   (o_drop_cnt),
        .o_state      (o_state)
    );

    // ---------------- clock / reset ----------------
    always #5 i_clk = ~i_clk;

    int cyc = 0;
    always @(posedge i_clk) cyc <= cyc + 1;

    initial begin
        #400000;
        $display("FAIL watchdog_timeout: simulation did not finish, cyc=%0d", cyc);
        $fatal(1);
    end

    // ---------------- handoff monitor ----------------
    logic [7:0] ho_q[$];
    int         ho_t[$];
    always @(negedge i_clk) begin
        if (!i_rst && bus.o_wvalid && bus.i_wready) begin
            ho_q.push_back(bus.o_wdata);
            ho_t.push_back(cyc);
        end
    end

    // ---------------- scoreboard ----------------
    int         checks = 0;
    int         errors = 0;
    logic [7:0] exp_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic check_order(input string name);
        for (int i = 0; i < exp_q.size(); i++) begin
            check($sformatf("%s_%0d", name, i),
                  (i < ho_q.size()) ? 32'(ho_q[i]) : 32'hFFFF_FFFF, 32'(exp_q[i]));
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic drive(input logic rr, input logic [7:0] rd, input logic wr);
        bus.i_eth_rready = rr;
        bus.i_eth_rdata  = rd;
        bus.i_wready     = wr;
    endtask

    task automatic hold_reset();
        drive(1'b0, 8'h00, 1'b0);
        i_rst = 1'b1;
        repeat (3) tick();
    endtask

    // Releasing #1 after an edge starts cycle 0.
    task automatic release_reset();
        i_rst = 1'b0;
        ho_q.delete();
        ho_t.delete();
    endtask

    // ---------------- reference model ----------------
    logic [7:0] m_q[$];
    bit         m_valid;
    logic [7:0] m_data;
    int         m_kind;   // 0: Ethernet byte, 1: frame start byte, 2: frame code byte
    int         m_wdog;
    bit         m_pend;
    int         m_drop;

    task automatic model_reset();
        m_q.delete();
        m_valid = 0;
        m_data  = 8'h00;
        m_kind  = 0;
        m_wdog  = W;
        m_pend  = 0;
        m_drop  = 0;
    endtask

    task automatic model_step(input bit rr, input logic [7:0] rd, input bit wr);
        bit xfer;
        bit code_done;
        bit popped;
        int depth_before;
        xfer         = m_valid && wr;
        code_done    = xfer && (m_kind == 2);
        popped       = 0;
        depth_before = m_q.size();
        if (xfer && m_kind == 1) begin
            m_data = 8'h65;
            m_kind = 2;
        end else if (xfer) begin
            m_valid = 0;
        end else if (!m_valid) begin
            if (m_pend) begin
                m_valid = 1;
                m_data  = 8'h68;
                m_kind  = 1;
            end else if (m_q.size() > 0) begin
                m_valid = 1;
                m_data  = m_q.pop_front();
                m_kind  = 0;
                popped  = 1;
            end
        end
        if (rr) begin
            if (depth_before < DEPTH || popped) m_q.push_back(rd);
            else if (m_drop < 255) m_drop++;
        end
        if (code_done) m_pend = 0;
        else if (m_wdog == 0) m_pend = 1;
        if (rr || code_done) m_wdog = W;
        else if (m_wdog > 0) m_wdog--;
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic          rr;
        logic [7:0]    rd;
        logic          wr;
        logic          ev;
        logic [7:0]    ed;
        logic [LW-1:0] el;
        logic [7:0]    edrop;
    } vec_t;

    vec_t tbl[NROWS];

    function automatic vec_t mk_vec(input logic rr, input logic [7:0] rd, input logic wr,
                                    input logic ev, input logic [7:0] ed,
                                    input logic [LW-1:0] el, input logic [7:0] edrop);
        vec_t v;
        v.rr = rr; v.rd = rd; v.wr = wr; v.ev = ev; v.ed = ed; v.el = el; v.edrop = edrop;
        return v;
    endfunction

    // ---------------- test ----------------
    int         found;
    int         first;
    int         gap;
    int         rp;
    int         wp;
    logic       r_rr;
    logic [7:0] r_rd;
    logic       r_wr;
    int         phase_rr[8] = '{50, 95, 0, 30, 5, 100, 60, 0};
    int         phase_wr[8] = '{90, 10, 100, 50, 95, 0, 40, 100};

    initial begin
        // Overflow with DEPTH=4, drain with bubbles, then the first heartbeat.
        tbl[0]  = mk_vec(1, 8'h10, 0, 0, 8'h00, 0, 0);
        tbl[1]  = mk_vec(1, 8'h11, 0, 0, 8'h00, 1, 0);
        tbl[2]  = mk_vec(1, 8'h12, 0, 1, 8'h10, 1, 0);
        tbl[3]  = mk_vec(1, 8'h13, 0, 1, 8'h10, 2, 0);
        tbl[4]  = mk_vec(1, 8'h14, 0, 1, 8'h10, 3, 0);
        tbl[5]  = mk_vec(1, 8'h15, 0, 1, 8'h10, 4, 0);
        tbl[6]  = mk_vec(1, 8'h16, 0, 1, 8'h10, 4, 1);
        tbl[7]  = mk_vec(0, 8'h00, 0, 1, 8'h10, 4, 2);
        tbl[8]  = mk_vec(0, 8'h00, 0, 1, 8'h10, 4, 2);
        tbl[9]  = mk_vec(0, 8'h00, 0, 1, 8'h10, 4, 2);
        tbl[10] = mk_vec(0, 8'h00, 1, 1, 8'h10, 4, 2);
        tbl[11] = mk_vec(0, 8'h00, 1, 0, 8'h00, 4, 2);
        tbl[12] = mk_vec(0, 8'h00, 1, 1, 8'h11, 3, 2);
        tbl[13] = mk_vec(0, 8'h00, 1, 0, 8'h00, 3, 2);
        tbl[14] = mk_vec(0, 8'h00, 1, 1, 8'h12, 2, 2);
        tbl[15] = mk_vec(0, 8'h00, 1, 0, 8'h00, 2, 2);
        tbl[16] = mk_vec(0, 8'h00, 1, 1, 8'h13, 1, 2);
        tbl[17] = mk_vec(0, 8'h00, 1, 0, 8'h00, 1, 2);
        tbl[18] = mk_vec(0, 8'h00, 1, 1, 8'h14, 0, 2);
        for (int r = 19; r <= 24; r++) tbl[r] = mk_vec(0, 8'h00, 1, 0, 8'h00, 0, 2);
        tbl[25] = mk_vec(0, 8'h00, 1, 1, 8'h68, 0, 2);
        tbl[26] = mk_vec(0, 8'h00, 1, 1, 8'h65, 0, 2);
        tbl[27] = mk_vec(0, 8'h00, 1, 0, 8'h00, 0, 2);

        // Reset values.
        hold_reset();
        check("rst_wvalid", bus.o_wvalid, 0);
        check("rst_wdata", bus.o_wdata, 8'h00);
        check("rst_busy", o_busy, 0);
        check("rst_level", o_fifo_level, 0);
        check("rst_drop", o_drop_cnt, 0);
        check("rst_state", 32'(o_state), 32'(IDLE));
        release_reset();

        for (int r = 0; r < NROWS; r++) begin
            check($sformatf("tbl%0d_wvalid", r), bus.o_wvalid, tbl[r].ev);
            if (tbl[r].ev) check($sformatf("tbl%0d_wdata", r), bus.o_wdata, tbl[r].ed);
            check($sformatf("tbl%0d_level", r), o_fifo_level, tbl[r].el);
            check($sformatf("tbl%0d_drop", r), o_drop_cnt, tbl[r].edrop);
            check($sformatf("tbl%0d_busy", r), o_busy, tbl[r].ev);
            drive(tbl[r].rr, tbl[r].rd, tbl[r].wr);
            tick();
        end

        // Reset mid-frame, right after the start byte has gone.
        drive(0, 8'h00, 1);
        found = 0;
        for (int k = 0; k < 40 && found == 0; k++) begin
            if (bus.o_wvalid && bus.o_wdata == 8'h68) found = 1;
            else tick();
        end
        check("midrst_found_start", found, 1);
        tick();
        check("midrst_code_pending", bus.o_wdata, 8'h65);
        check("midrst_drop_before", o_drop_cnt, 2);
        i_rst = 1'b1;
        #1;
        check("midrst_wvalid_async", bus.o_wvalid, 0);
        check("midrst_level", o_fifo_level, 0);
        check("midrst_drop", o_drop_cnt, 0);
        check("midrst_busy", o_busy, 0);
        repeat (2) tick();
        release_reset();
        drive(0, 8'h00, 1);
        first = -1;
        for (int c = 0; c < 30 && first < 0; c++) begin
            if (bus.o_wvalid) first = c;
            else tick();
        end
        check("hb_first_cycle", first, 18);
        check("hb_start_byte", bus.o_wdata, 8'h68);
        tick();
        check("hb_code_valid", bus.o_wvalid, 1);
        check("hb_code_byte", bus.o_wdata, 8'h65);
        tick();
        check("hb_end_idle", bus.o_wvalid, 0);
        gap = 1;
        while (!bus.o_wvalid && gap < 40) begin
            tick();
            gap++;
        end
        check("hb_period", gap, 19);

        // Backpressure: first byte held, then in-order with one bubble between bytes.
        hold_reset();
        release_reset();
        for (int c = 0; c < 12; c++) begin
            if (c >= 2) begin
                check($sformatf("bp_hold_valid_c%0d", c), bus.o_wvalid, 1);
                check($sformatf("bp_hold_data_c%0d", c), bus.o_wdata, 8'h01);
            end
            drive(c < 3, (c < 3) ? 8'(c + 1) : 8'h00, 0);
            tick();
        end
        ho_q.delete();
        ho_t.delete();
        drive(0, 8'h00, 1);
        for (int k = 0; k < 40 && ho_q.size() < 3; k++) tick();
        exp_q = '{8'h01, 8'h02, 8'h03};
        check_order("bp_order");
        check("bp_gap01", (ho_t.size() >= 3) ? 32'(ho_t[1] - ho_t[0]) : 32'hFFFF_FFFF, 2);
        check("bp_gap12", (ho_t.size() >= 3) ? 32'(ho_t[2] - ho_t[1]) : 32'hFFFF_FFFF, 2);

        // Contention: heartbeat becomes pending while a byte stalls with 3 queued.
        hold_reset();
        release_reset();
        for (int c = 0; c < 24; c++) begin
            drive(c < 4, (c < 4) ? 8'(8'h21 + c) : 8'h00, 0);
            tick();
        end
        check("cont_stalled_byte", bus.o_wdata, 8'h21);
        check("cont_level", o_fifo_level, 3);
        ho_q.delete();
        ho_t.delete();
        drive(0, 8'h00, 1);
        for (int k = 0; k < 60 && ho_q.size() < 6; k++) tick();
        exp_q = '{8'h21, 8'h68, 8'h65, 8'h22, 8'h23, 8'h24};
        check_order("cont_order");
        check("cont_frame_atomic", (ho_t.size() >= 3) ? 32'(ho_t[2] - ho_t[1]) : 32'hFFFF_FFFF, 1);

        // Random traffic in phases of differing load and backpressure.
        hold_reset();
        release_reset();
        model_reset();
        for (int p = 0; p < 8; p++) begin
            rp = phase_rr[p];
            wp = phase_wr[p];
            for (int n = 0; n < 80; n++) begin
                check("rnd_wvalid", bus.o_wvalid, m_valid);
                if (m_valid) check("rnd_wdata", bus.o_wdata, m_data);
                check("rnd_level", o_fifo_level, m_q.size());
                check("rnd_drop", o_drop_cnt, m_drop);
                check("rnd_busy", o_busy, m_valid);
                r_rr = ($urandom_range(0, 99) < rp);
                r_rd = 8'($urandom_range(0, 255));
                r_wr = ($urandom_range(0, 99) < wp);
                drive(r_rr, r_rd, r_wr);
                model_step(r_rr, r_rd, r_wr);
                tick();
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
